// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: decode-side control, instruction-memory port and presented instruction.
interface fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_re;
  logic [31:0] imem_dout;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        bubble;
  logic [31:0] fetch_count;

  modport master (
    input  stall, redirect, redirect_pc, imem_dout,
    output imem_addr, imem_re, instr, pc, bubble, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_dout,
    input  imem_addr, imem_re, instr, pc, bubble, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads a 1-cycle synchronous imem, holds the
// presented instruction across decode stalls and bubbles on boot/redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);
  localparam int unsigned XLEN = 32;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic [XLEN-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] imem_addr_c;
  logic            imem_re_c;
  logic [XLEN-1:0] instr_c;
  logic            bubble_c;

  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] pc_inc;

  assign redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign pc_inc   = pc_q + XLEN'(4);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and memory/decode-facing outputs
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    imem_re_c   = 1'b0;
    imem_addr_c = pc_q;
    instr_c     = bus.imem_dout;
    bubble_c    = 1'b0;

    case (state_q)
      ST_BOOT: begin
        bubble_c  = 1'b1;
        imem_re_c = 1'b1;
        state_d   = ST_RUN;
        if (bus.redirect) begin
          imem_addr_c = redir_pc;
          pc_d        = redir_pc;
        end
      end

      ST_RUN, ST_HOLD: begin
        if (state_q == ST_HOLD) instr_c = hold_q;
        if (bus.redirect) begin
          bubble_c    = 1'b1;
          imem_re_c   = 1'b1;
          imem_addr_c = redir_pc;
          pc_d        = redir_pc;
          state_d     = ST_RUN;
        end else if (bus.stall) begin
          // Memory output is only valid the cycle after a read, so capture it once.
          if (state_q == ST_RUN) hold_d = bus.imem_dout;
          state_d = ST_HOLD;
        end else begin
          imem_re_c   = 1'b1;
          imem_addr_c = pc_inc;
          pc_d        = pc_inc;
          cnt_d       = cnt_q + XLEN'(1);
          state_d     = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign bus.imem_addr   = imem_addr_c;
  assign bus.imem_re     = imem_re_c;
  assign bus.instr       = instr_c;
  assign bus.pc          = pc_q;
  assign bus.bubble      = bubble_c;
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a word-equals-address instruction memory.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mem_q;
  logic [31:0] scr = 32'h0;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h4000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous memory; output is scrambled when no read is issued
  always @(posedge clk) begin
    scr <= scr + 32'd1;
    if (bus.imem_re) mem_q <= bus.imem_addr;
    else             mem_q <= 32'hBAD0_0000 ^ scr;
  end
  assign bus.imem_dout = mem_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic st, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    rst_n = rn;
    bus.stall = st;
    bus.redirect = rd;
    bus.redirect_pc = rpc;
    #1;
  endtask

  // Presented instruction and memory request for the current cycle
  task automatic expect_cyc(input string tag, input logic chk_ins, input logic [31:0] p,
                            input logic bub, input logic re, input logic [31:0] addr,
                            input logic [31:0] cnt);
    if (chk_ins) chk({tag, ".instr"}, bus.instr, p);
    chk({tag, ".pc"}, bus.pc, p);
    chk({tag, ".bubble"}, 32'(bus.bubble), 32'(bub));
    chk({tag, ".imem_re"}, 32'(bus.imem_re), 32'(re));
    if (re) chk({tag, ".imem_addr"}, bus.imem_addr, addr);
    chk({tag, ".fetch_count"}, bus.fetch_count, cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    repeat (2) @(posedge clk);

    drive(1, 0, 0, 0);
    expect_cyc("boot", 0, 32'h4000_0000, 1, 1, 32'h4000_0000, 0);
    drive(1, 0, 0, 0);
    expect_cyc("run0", 1, 32'h4000_0000, 0, 1, 32'h4000_0004, 0);
    drive(1, 0, 0, 0);
    expect_cyc("run1", 1, 32'h4000_0004, 0, 1, 32'h4000_0008, 1);

    // Stall three cycles on 4000_0008
    drive(1, 1, 0, 0);
    expect_cyc("stall0", 1, 32'h4000_0008, 0, 0, 0, 2);
    drive(1, 1, 0, 0);
    expect_cyc("stall1", 1, 32'h4000_0008, 0, 0, 0, 2);
    drive(1, 1, 0, 0);
    expect_cyc("stall2", 1, 32'h4000_0008, 0, 0, 0, 2);
    drive(1, 0, 0, 0);
    expect_cyc("release", 1, 32'h4000_0008, 0, 1, 32'h4000_000C, 2);

    // Redirect in RUN with misaligned target
    drive(1, 0, 1, 32'h4000_0102);
    expect_cyc("redir_run", 1, 32'h4000_000C, 1, 1, 32'h4000_0100, 3);
    drive(1, 0, 0, 0);
    expect_cyc("redir_tgt", 1, 32'h4000_0100, 0, 1, 32'h4000_0104, 3);

    // Redirect and stall together while in HOLD
    drive(1, 1, 0, 0);
    expect_cyc("stall_b", 1, 32'h4000_0104, 0, 0, 0, 4);
    drive(1, 1, 1, 32'h4000_0200);
    expect_cyc("redir_hold", 1, 32'h4000_0104, 1, 1, 32'h4000_0200, 4);
    drive(1, 0, 0, 0);
    expect_cyc("after_hold", 1, 32'h4000_0200, 0, 1, 32'h4000_0204, 4);

    // PC wrap
    drive(1, 0, 1, 32'hFFFF_FFFF);
    expect_cyc("redir_top", 1, 32'h4000_0204, 1, 1, 32'hFFFF_FFFC, 5);
    drive(1, 0, 0, 0);
    expect_cyc("top", 1, 32'hFFFF_FFFC, 0, 1, 32'h0000_0000, 5);
    drive(1, 1, 0, 0);
    expect_cyc("wrapped", 1, 32'h0000_0000, 0, 0, 0, 6);

    // Reset while in HOLD, with redirect and stall also asserted
    drive(0, 1, 1, 32'h1234_5678);
    drive(1, 0, 0, 0);
    expect_cyc("reboot", 0, 32'h4000_0000, 1, 1, 32'h4000_0000, 0);
    drive(1, 0, 0, 0);
    expect_cyc("rerun", 1, 32'h4000_0000, 0, 1, 32'h4000_0004, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that feeds the decode/register-read stage. It owns the program counter and issues reads to a synchronous instruction memory with one cycle of latency. It presents each returned instruction with its PC, and tells decode to insert a bubble after boot or on a redirect. A hold register keeps the presented instruction stable while decode is stalled, because memory output is undefined when no read is issued.

## Interface
- RESET_PC, 32'h4000_0000, PC of the first fetched instruction after reset.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- stall  in  1  decode cannot accept; hold the presented instruction.
- redirect  in  1  taken branch/jump from execute; overrides stall.
- redirect_pc  in  32  target PC; bits [1:0] are treated as 0.
- imem_addr  out  32  byte address of the read issued this cycle.
- imem_re  out  1  read enable; data appears on imem_dout next cycle.
- imem_dout  in  32  read data for the previous cycle's imem_addr.
- instr  out  32  instruction presented to decode.
- pc  out  32  PC of instr.
- bubble  out  1  instr is invalid; drives decode's bubble input.
- fetch_count  out  32  number of instructions accepted by decode; wraps.

## Operation
- Registers: state (BOOT, RUN, HOLD), pc_q, hold_q, fetch_count. pc = pc_q.
- Reset (rst_n=0 at an edge):
  - state<=BOOT, pc_q<=RESET_PC, fetch_count<=0.
  - hold_q is don't-care.
- BOOT:
  - imem_re=1, imem_addr=pc_q, bubble=1, instr=imem_dout (don't-care).
  - Next state is RUN; stall is ignored.
  - If redirect: imem_addr=redirect_pc, pc_q<=redirect_pc.
- RUN: instr=imem_dout.
  - redirect: bubble=1, imem_re=1, imem_addr=redirect_pc, pc_q<=redirect_pc, stay RUN.
  - else stall: bubble=0, imem_re=0, hold_q<=imem_dout, go to HOLD.
  - else (accept): bubble=0, imem_re=1, imem_addr=pc_q+4, pc_q<=pc_q+4, fetch_count+1.
- HOLD: instr=hold_q, bubble=0.
  - redirect: same as RUN redirect, go to RUN.
  - else stall: imem_re=0, stay HOLD.
  - else (accept): imem_re=1, imem_addr=pc_q+4, pc_q<=pc_q+4, fetch_count+1, go to RUN.
- imem_addr is a don't-care whenever imem_re=0.
- Arithmetic:
  - pc_q+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - fetch_count wraps at 2^32.
  - Redirect targets are used with [1:0] cleared.
- Simultaneous redirect and stall: redirect wins. The presented instruction is marked bubble and fetch_count does not increment.
- A redirect in the same cycle as an accept condition counts as a redirect, not an accept.

## Timing
- Fetch latency is 1 cycle: a read issued in cycle t is presented in t+1 with pc = that address.
- First valid instruction: the second cycle after reset release (BOOT is one cycle).
- Redirect penalty at fetch: exactly one bubble cycle, the cycle redirect is high.
  - The next cycle presents the instruction at redirect_pc.
- Stall:
  - instr and pc are identical every stalled cycle.
  - No reads are issued while stalled.
  - The cycle after stall falls presents pc_q+4 with no bubble.
- Reset mid-operation: reset overrides redirect/stall. HOLD contents are discarded and the next cycle is BOOT.

## Test plan
- Reset, memory returns word = address: after reset, cycle 0 bubble=1 with imem_addr=32'h4000_0000. Following cycles present pc 4000_0000, 4000_0004, 4000_0008 with matching instr and bubble=0. fetch_count reaches 3 after three accepts.
- Stall held 3 cycles while pc=4000_0008:
  - imem_re=0 for 3 cycles and instr stays 4000_0008; memory output is scrambled during the stall.
  - After release, the next pc is 4000_000C, and fetch_count is unchanged during the stall.
- Redirect to 32'h4000_0102 in RUN: bubble=1 that cycle and imem_addr=4000_0100. The next cycle shows pc=4000_0100 valid, and fetch_count does not increment on the redirect cycle.
- Redirect and stall together while in HOLD: redirect wins. The next cycle presents redirect_pc in RUN and the hold contents are discarded.
- PC wrap: redirect to FFFF_FFFC, then accept. The next pc is 0000_0000.
- Reset asserted while in HOLD: the next cycle is BOOT with bubble=1, pc=RESET_PC and fetch_count=0.
